// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared types and constants for the FIFO read-side stream engine
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int BUF_DEPTH  = 2;
    localparam int BUF_CNT_W  = 2;
    localparam int WORD_CNT_W = 16;

    function automatic int pkt_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus output stream bundle; FIFO_RD_STREAM_LAST_EN adds m_last
interface fifo_rd_stream_if #(parameter int DSIZE = 8);

    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
`ifdef FIFO_RD_STREAM_LAST_EN
    logic             m_last;

    modport master (output rinc, m_valid, m_data, m_last, input rdata, rempty, m_ready);
    modport slave  (input rinc, m_valid, m_data, m_last, output rdata, rempty, m_ready);
`else
    modport master (output rinc, m_valid, m_data, input rdata, rempty, m_ready);
    modport slave  (input rinc, m_valid, m_data, output rdata, rempty, m_ready);
`endif

endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry prefetch buffer with push/pop/clear; head entry is registered
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DSIZE-1:0]     push_data,
    input  logic                 pop,
    input  logic                 clear,
    output logic [DSIZE-1:0]     head_data,
    output logic [BUF_CNT_W-1:0] count
);

    logic [DSIZE-1:0] mem [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop)      count <= count + BUF_CNT_W'(1);
            else if (!push && pop) count <= count - BUF_CNT_W'(1);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains fifo_sync into a valid/ready stream; FIFO_RD_STREAM_LAST_EN adds m_last
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int BUF_DEPTH = fifo_rd_stream_pkg::BUF_DEPTH,
    parameter int CNT_W     = WORD_CNT_W
`ifdef FIFO_RD_STREAM_LAST_EN
    ,
    parameter int PKT_LEN   = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_stream_if.master  bus,
    input  logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   inflight;
    logic [BUF_CNT_W-1:0]   buf_count;
    logic                   pop;
    logic                   push;
    logic                   rinc_c;
    logic [2:0]             occupied;
    logic [2:0]             room;

    assign pop         = bus.m_valid && bus.m_ready;
    // The word returning during FLUSH belongs to discarded history.
    assign push        = inflight && (state != FLUSH);
    assign bus.m_valid = (buf_count != '0);
    assign bus.rinc    = rinc_c;
    assign busy        = (state != IDLE) || bus.m_valid;

    fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.rdata),
        .pop       (pop),
        .clear     (flush),
        .head_data (bus.m_data),
        .count     (buf_count)
    );

    always_comb begin
        rinc_c    = 1'b0;
        state_nxt = state;
        occupied  = {1'b0, buf_count} + {2'b00, inflight} + 3'd1;
        room      = 3'(BUF_DEPTH) + {2'b00, pop};
        if (!bus.rempty && (state != FLUSH) && (occupied <= room)) rinc_c = 1'b1;
        case (state)
            IDLE: begin
                if (flush)       state_nxt = FLUSH;
                else if (rinc_c) state_nxt = STREAM;
            end
            STREAM: begin
                if (flush) state_nxt = FLUSH;
                else if ((buf_count == '0) && !inflight && bus.rempty) state_nxt = IDLE;
            end
            FLUSH: begin
                if (!inflight) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rinc_c;
            if (pop) word_cnt <= word_cnt + CNT_W'(1);
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int PKT_W = pkt_w(PKT_LEN);

    logic [PKT_W-1:0] pkt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else if (flush) begin
            pkt_cnt <= '0;
        end else if (pop) begin
            pkt_cnt <= (pkt_cnt == PKT_W'(PKT_LEN - 1)) ? '0 : pkt_cnt + PKT_W'(1);
        end
    end

    assign bus.m_last = bus.m_valid && (pkt_cnt == PKT_W'(PKT_LEN - 1));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream; FIFO_RD_STREAM_LAST_EN also checks m_last
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        busy;
    logic [15:0] word_cnt;

    fifo_rd_stream_if #(.DSIZE(8)) bus ();

    fifo_rd_stream #(.DSIZE(8), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flush    (flush),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural fifo_sync: array storage, pop-then-data-next-cycle read port.
    logic [7:0] mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.rempty = (rd_ptr == wr_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= wr_ptr;
            bus.rdata <= 8'h00;
        end else if (bus.rinc) begin
            bus.rdata <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int PKT_LEN = 4;
`endif

    // Scoreboard: every written word is expected in order, except words already
    // taken from the FIFO but not yet delivered when a flush happens.
    logic [7:0] exp_q [$];
    int         exp_wr  = 0;
    int         n_deliv = 0;
    int         pkt_idx = 0;
    int         level;
    int         drop;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] expd;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_wr     = wr_ptr;
                n_deliv    = 0;
                pkt_idx    = 0;
                prev_stall = 1'b0;
            end else begin
                while (exp_wr != wr_ptr) begin
                    exp_q.push_back(mem[exp_wr % 1024]);
                    exp_wr++;
                end
                level = wr_ptr - rd_ptr;
                check("word_cnt_track", word_cnt, n_deliv[15:0]);
                check("outstanding_le2", (exp_q.size() - level) <= 2, 1);
                check("no_rinc_when_empty", bus.rinc && bus.rempty, 0);
                if (prev_stall) begin
                    check("stall_valid_hold", bus.m_valid, 1);
                    check("stall_data_hold", bus.m_data, prev_data);
                end
                if (bus.m_valid && bus.m_ready) begin
                    check("sb_has_word", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        expd = exp_q.pop_front();
                        check("m_data_order", bus.m_data, expd);
                    end
`ifdef FIFO_RD_STREAM_LAST_EN
                    check("m_last", bus.m_last, pkt_idx == PKT_LEN - 1);
                    pkt_idx = (pkt_idx + 1) % PKT_LEN;
`endif
                    n_deliv++;
                end
                prev_stall = bus.m_valid && !bus.m_ready && !flush;
                prev_data  = bus.m_data;
                if (flush) begin
                    drop = exp_q.size() - (level - int'(bus.rinc));
                    repeat (drop) void'(exp_q.pop_front());
                    pkt_idx = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int c;
        c = 0;
        while ((busy || !bus.rempty) && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        check(name, busy || !bus.rempty, 0);
    endtask

    logic [31:0] rmask;
    logic [31:0] vmask;
    int          npop;

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_rinc", bus.rinc, 0);
        check("rst_busy", busy, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_m_data", bus.m_data, 0);
        step();
        rst = 1'b0;

        // Three preloaded words with a ready sink.
        step();
        put(8'h11); put(8'h22); put(8'h33);
        bus.m_ready = 1'b1;
        rmask = '0;
        vmask = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rinc)    rmask[c] = 1'b1;
            if (bus.m_valid) vmask[c] = 1'b1;
        end
        check("t1_rinc_pattern", rmask, 32'h7);
        check("t1_valid_pattern", vmask, 32'h1c);
        check("t1_word_cnt", word_cnt, 3);
        check("t1_busy_idle", busy, 0);

        // Stalled sink: only two pops fit, head holds.
        step();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) put(8'(i));
        npop = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rinc) npop++;
        end
        check("t2_pops_during_stall", npop, 2);
        check("t2_hold_valid", bus.m_valid, 1);
        check("t2_hold_data", bus.m_data, 8'h01);
        step();
        bus.m_ready = 1'b1;
        wait_idle(40, "t2_drain_timeout");
        check("t2_word_cnt", word_cnt, 11);

        // Toggling ready with random data.
        step();
        for (int i = 0; i < 16; i++) put(8'($urandom_range(0, 255)));
        for (int c = 0; c < 60; c++) begin
            step();
            bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b1;
        wait_idle(40, "t3_drain_timeout");
        check("t3_word_cnt", word_cnt, 27);

        // Flush with one buffered and one in-flight word.
        step();
        bus.m_ready = 1'b0;
        put(8'hA0); put(8'hA1); put(8'hA2); put(8'hA3);
        @(negedge clk);
        @(negedge clk);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("t4_pre_flush_valid", bus.m_valid, 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t4_flush_valid_low", bus.m_valid, 0);
        check("t4_flush_rinc_low", bus.rinc, 0);
        check("t4_flush_word_cnt", word_cnt, 27);
        step();
        bus.m_ready = 1'b1;
        wait_idle(40, "t4_drain_timeout");
        check("t4_word_cnt", word_cnt, 29);

        // Asynchronous reset in the middle of a stream.
        step();
        for (int i = 0; i < 6; i++) put(8'(8'hB0 + i));
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_m_valid", bus.m_valid, 0);
        check("t5_rst_rinc", bus.rinc, 0);
        check("t5_rst_word_cnt", word_cnt, 0);
        step();
        step();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_post_busy", busy, 0);
        check("t5_post_m_valid", bus.m_valid, 0);
        check("t5_post_word_cnt", word_cnt, 0);

`ifdef FIFO_RD_STREAM_LAST_EN
        // Packet framing, then a flush after word 2 restarts the count.
        step();
        for (int i = 0; i < 8; i++) put(8'(8'hC0 + i));
        wait_idle(40, "t6_pkt_timeout");
        step();
        put(8'hD0); put(8'hD1);
        wait_idle(40, "t6_two_timeout");
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) put(8'(8'hE0 + i));
        wait_idle(40, "t6_restart_timeout");
        check("t6_word_cnt", word_cnt, 14);
`endif

        // Random traffic: random ready, writes and occasional flush pulses.
        for (int c = 0; c < 600; c++) begin
            step();
            bus.m_ready = ($urandom_range(0, 3) != 0);
            flush       = !flush && ($urandom_range(0, 49) == 0);
            if (($urandom_range(0, 2) != 0) && ((wr_ptr - rd_ptr) < 16))
                put(8'($urandom_range(0, 255)));
        end
        step();
        flush       = 1'b0;
        bus.m_ready = 1'b1;
        wait_idle(100, "rand_drain_timeout");
        step();
        check("rand_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
